// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (transmit and receive sides).
// Holds the link state encoding, the error-counter ceiling and default geometry.
// No ports; import with tdm_pkg::*.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } tdm_state_t;

  localparam logic [7:0] ERR_MAX = 8'hFF;

  // Default link geometry, shared with the TDM transmitter
  localparam int TDM_NCH = 4;
  localparam int TDM_W   = 7;

endpackage

// File: rtl/tdm_frame_tracker.sv
// Frame alignment tracker: HUNT/RUN FSM, slot counter, frame_done/frame_err pulses, saturating err_count.
// Ports: clk/rst; i_valid/i_sync beat qualifiers; o_wr_en/o_wr_slot write command (combinational, same cycle);
//        o_frame_done/o_frame_err/o_locked/o_err_count registered status (1 cycle after the beat).
module tdm_frame_tracker
  import tdm_pkg::*;
#(
  parameter  int NCH = TDM_NCH,
  localparam int CW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  input  logic          i_sync,
  output logic          o_wr_en,
  output logic [CW-1:0] o_wr_slot,
  output logic          o_frame_done,
  output logic          o_frame_err,
  output logic          o_locked,
  output logic [7:0]    o_err_count
);

  localparam logic [CW-1:0] LAST_SLOT = CW'(NCH - 1);

  tdm_state_t    r_state;
  tdm_state_t    w_state_nxt;
  logic [CW-1:0] r_slot;
  logic [CW-1:0] w_slot_nxt;
  logic [CW-1:0] w_slot_inc;
  logic          w_wr_en;
  logic [CW-1:0] w_wr_slot;
  logic          w_err;
  logic          w_done;
  logic          r_frame_done;
  logic          r_frame_err;
  logic          r_locked;
  logic [7:0]    r_err_cnt;

  assign w_slot_inc = (r_slot == LAST_SLOT) ? '0 : r_slot + CW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next state / slot
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    if (i_valid) begin
      if (r_state == HUNT) begin
        if (i_sync) begin
          w_state_nxt = RUN;
          w_slot_nxt  = CW'(1);
        end
      end else begin
        if (i_sync) begin
          // Normal frame start or early-sync realignment: both restart at slot 1
          w_slot_nxt = CW'(1);
        end else if (r_slot == '0) begin
          // Expected a sync here; alignment lost
          w_state_nxt = HUNT;
          w_slot_nxt  = '0;
        end else begin
          w_slot_nxt = w_slot_inc;
        end
      end
    end
  end

  // Outputs: write command and error event
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_slot = '0;
    w_err     = 1'b0;
    if (i_valid) begin
      if (r_state == HUNT) begin
        w_wr_en = i_sync;
      end else if (i_sync) begin
        w_wr_en = 1'b1;
        w_err   = (r_slot != '0);
      end else if (r_slot == '0) begin
        w_err = 1'b1;
      end else begin
        w_wr_en   = 1'b1;
        w_wr_slot = r_slot;
      end
    end
  end

  assign w_done = w_wr_en && (w_wr_slot == LAST_SLOT);

  // Status pulses registered so they line up with the channel update strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      r_locked     <= (w_state_nxt == RUN);
      if (w_err && (r_err_cnt != ERR_MAX)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_wr_en      = w_wr_en;
  assign o_wr_slot    = w_wr_slot;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_locked     = r_locked;
  assign o_err_count  = r_err_cnt;

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: aligns to frames and routes each beat into its channel holding register.
// Ports: clk/rst; in_valid/in_sync/in_data beat input (no backpressure, consumed or dropped in-cycle);
//        ch_data/ch_upd channel registers and one-hot update strobe; frame_done/frame_err/locked/err_count status.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int NCH = TDM_NCH,
  parameter  int W   = TDM_W,
  localparam int CW  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [W-1:0]     in_data,
  output logic [NCH*W-1:0] ch_data,
  output logic [NCH-1:0]   ch_upd,
  output logic             frame_done,
  output logic             frame_err,
  output logic             locked,
  output logic [7:0]       err_count
);

  logic                    w_wr_en;
  logic [CW-1:0]           w_wr_slot;
  logic [NCH-1:0][W-1:0]   r_ch_data;
  logic [NCH-1:0]          r_ch_upd;

  tdm_frame_tracker #(.NCH(NCH)) u_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (in_valid),
    .i_sync       (in_sync),
    .o_wr_en      (w_wr_en),
    .o_wr_slot    (w_wr_slot),
    .o_frame_done (frame_done),
    .o_frame_err  (frame_err),
    .o_locked     (locked),
    .o_err_count  (err_count)
  );

  // Channel register file; unwritten channels hold their value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch_data <= '0;
      r_ch_upd  <= '0;
    end else begin
      r_ch_upd <= '0;
      if (w_wr_en) begin
        r_ch_data[w_wr_slot] <= in_data;
        r_ch_upd             <= NCH'(1) << w_wr_slot;
      end
    end
  end

  assign ch_data = r_ch_data;
  assign ch_upd  = r_ch_upd;

endmodule

// File: tb/tb_tdm_demux.sv
module tb_tdm_demux;

  localparam int NCH = 4;
  localparam int W   = 7;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_sync;
  logic [W-1:0]     in_data;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_upd;
  logic             frame_done;
  logic             frame_err;
  logic             locked;
  logic [7:0]       err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: link view in terms of "locked" and "position within frame"
  logic [W-1:0]   m_ch [NCH];
  bit             m_lock;
  int             m_pos;
  int             m_err;
  logic [NCH-1:0] e_upd;
  bit             e_done;
  bit             e_err;

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .in_data    (in_data),
    .ch_data    (ch_data),
    .ch_upd     (ch_upd),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .locked     (locked),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int k, input logic [W-1:0] d);
    m_ch[k] = d;
    e_upd   = '0;
    e_upd[k] = 1'b1;
  endtask

  task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    e_upd  = '0;
    e_done = 0;
    e_err  = 0;
    if (r) begin
      for (int k = 0; k < NCH; k++) m_ch[k] = '0;
      m_lock = 0;
      m_pos  = 0;
      m_err  = 0;
    end else if (v) begin
      if (!m_lock) begin
        if (s) begin
          model_write(0, d);
          m_lock = 1;
          m_pos  = 1;
        end
      end else if (s) begin
        e_err = (m_pos != 0);
        model_write(0, d);
        m_pos = 1;
      end else if (m_pos == 0) begin
        e_err  = 1;
        m_lock = 0;
      end else begin
        model_write(m_pos, d);
        m_pos = (m_pos + 1) % NCH;
        e_done = (m_pos == 0);
      end
      if (e_err && m_err < 255) m_err++;
    end
  endtask

  task automatic check_all();
    logic [NCH*W-1:0] e_ch;
    for (int k = 0; k < NCH; k++) e_ch[k*W +: W] = m_ch[k];
    chk("ch_data", 64'(ch_data), 64'(e_ch));
    chk("ch_upd", 64'(ch_upd), 64'(e_upd));
    chk("frame_done", 64'(frame_done), 64'(e_done));
    chk("frame_err", 64'(frame_err), 64'(e_err));
    chk("locked", 64'(locked), 64'(m_lock));
    chk("err_count", 64'(err_count), 64'(m_err));
  endtask

  // One clock of stimulus, then compare against the model 1 ns after the edge
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst      = r;
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    model(r, v, s, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'($urandom_range(0, 1)), rnd());
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    for (int k = 0; k < NCH; k++) m_ch[k] = 'x;

    // Reset has priority over a simultaneous sync beat
    step(1, 1, 1, 7'h55);
    chk("reset_locked", 64'(locked), 64'd0);

    // Clean frame
    step(0, 1, 1, 7'h11);
    chk("clean_upd0", 64'(ch_upd), 64'b0001);
    step(0, 1, 0, 7'h22);
    step(0, 1, 0, 7'h33);
    step(0, 1, 0, 7'h44);
    chk("clean_upd3", 64'(ch_upd), 64'b1000);
    chk("clean_done", 64'(frame_done), 64'd1);
    chk("clean_data", 64'(ch_data), 64'({7'h44, 7'h33, 7'h22, 7'h11}));
    idle(1);

    // HUNT discards unsynced beats
    step(1, 0, 0, 7'h00);
    step(0, 1, 0, 7'h05);
    step(0, 1, 0, 7'h06);
    chk("hunt_no_upd", 64'(ch_upd), 64'd0);
    step(0, 1, 1, 7'h01);
    chk("hunt_lock", 64'(locked), 64'd1);

    // Frame with 3 idle cycles between beats
    step(1, 0, 0, 7'h00);
    step(0, 1, 1, 7'h11); idle(3);
    step(0, 1, 0, 7'h22); idle(3);
    step(0, 1, 0, 7'h33); idle(3);
    step(0, 1, 0, 7'h44);
    chk("gap_done", 64'(frame_done), 64'd1);
    chk("gap_data", 64'(ch_data), 64'({7'h44, 7'h33, 7'h22, 7'h11}));
    idle(3);

    // Missing sync after a full frame
    step(0, 1, 0, 7'h7F);
    chk("miss_err", 64'(frame_err), 64'd1);
    chk("miss_cnt", 64'(err_count), 64'd1);
    chk("miss_data", 64'(ch_data), 64'({7'h44, 7'h33, 7'h22, 7'h11}));
    idle(1);

    // Early sync realigns without losing lock
    step(1, 0, 0, 7'h00);
    step(0, 1, 1, 7'h01);
    step(0, 1, 0, 7'h02);
    step(0, 1, 1, 7'h03);
    chk("early_err", 64'(frame_err), 64'd1);
    step(0, 1, 0, 7'h04);
    chk("early_ch1", 64'(ch_data[W +: W]), 64'h04);
    chk("early_ch0", 64'(ch_data[0 +: W]), 64'h03);
    chk("early_cnt", 64'(err_count), 64'd1);

    // Error counter saturation
    step(1, 0, 0, 7'h00);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 1, rnd());
      for (int j = 1; j < NCH; j++) step(0, 1, 0, rnd());
      step(0, 1, 0, rnd());
    end
    chk("sat_cnt", 64'(err_count), 64'd255);

    // Reset in the middle of a frame
    step(0, 1, 1, 7'h21);
    step(0, 1, 0, 7'h22);
    step(1, 1, 0, 7'h23);
    chk("midrst_data", 64'(ch_data), 64'd0);
    chk("midrst_done", 64'(frame_done), 64'd0);
    step(0, 1, 0, 7'h24);
    chk("midrst_hunt", 64'(ch_upd), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 3) == 0), rnd());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
